// File: rtl/irq_conditioner.sv
// Per-channel interrupt conditioner: synchronizer, debounce filter, rising-edge
// detect and a pending latch held until the CPU acknowledges it.
module irq_conditioner #(
    parameter int N_IRQ           = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACTIVE_HIGH     = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_IRQ-1:0] irq_raw,
    input  logic [N_IRQ-1:0] irq_ack,
    output logic [N_IRQ-1:0] irq_pending,
    output logic [N_IRQ-1:0] irq_level,
    output logic [N_IRQ-1:0] irq_lost
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [N_IRQ-1:0] in_s;
    logic [N_IRQ-1:0] sync1_r;
    logic [N_IRQ-1:0] sync2_r;
    logic [N_IRQ-1:0] stable_r;
    logic [CNT_W-1:0] cnt_r [N_IRQ];
    logic [N_IRQ-1:0] accept_s;
    logic [N_IRQ-1:0] rise_s;

    // Normalise input polarity so everything downstream treats 1 as asserted.
    always_comb begin
        if (ACTIVE_HIGH != 0) begin
            in_s = irq_raw;
        end else begin
            in_s = ~irq_raw;
        end
    end

    // Accept a new level once it has disagreed with stable for the full window.
    always_comb begin
        accept_s = {N_IRQ{1'b0}};
        rise_s   = {N_IRQ{1'b0}};
        for (int i = 0; i < N_IRQ; i++) begin
            if ((sync2_r[i] != stable_r[i]) && (cnt_r[i] == CNT_LAST)) begin
                accept_s[i] = 1'b1;
            end else begin
                accept_s[i] = 1'b0;
            end
            rise_s[i] = accept_s[i] & sync2_r[i];
        end
    end

    // Synchronizer, debounce counters, pending latch and sticky over-run flags.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_r     <= {N_IRQ{1'b0}};
            sync2_r     <= {N_IRQ{1'b0}};
            stable_r    <= {N_IRQ{1'b0}};
            irq_pending <= {N_IRQ{1'b0}};
            irq_lost    <= {N_IRQ{1'b0}};
            for (int i = 0; i < N_IRQ; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            sync1_r     <= in_s;
            sync2_r     <= sync1_r;
            // Set wins over ack so an edge coinciding with the acknowledge is kept.
            irq_pending <= rise_s | (irq_pending & ~irq_ack);
            irq_lost    <= irq_lost | (rise_s & irq_pending & ~irq_ack);
            for (int i = 0; i < N_IRQ; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    cnt_r[i] <= CNT_ZERO;
                end else if (accept_s[i]) begin
                    stable_r[i] <= sync2_r[i];
                    cnt_r[i]    <= CNT_ZERO;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    assign irq_level = stable_r;

endmodule

// File: tb/tb_irq_conditioner.sv
// Directed bench for irq_conditioner: default active-high instance plus a
// single-channel active-low instance, checked with immediate assertions.
module tb_irq_conditioner;

    logic       clk = 1'b0;
    logic       clr;
    logic [2:0] irq_raw;
    logic [2:0] irq_ack;
    logic [2:0] pend;
    logic [2:0] lvl;
    logic [2:0] lost;
    logic [0:0] raw_n;
    logic [0:0] ack_n;
    logic [0:0] pend_n;
    logic [0:0] lvl_n;
    logic [0:0] lost_n;

    int tests  = 0;
    int failed = 0;

    irq_conditioner #(.N_IRQ(3), .DEBOUNCE_CYCLES(4), .ACTIVE_HIGH(1)) dut (
        .clk(clk), .clr(clr), .irq_raw(irq_raw), .irq_ack(irq_ack),
        .irq_pending(pend), .irq_level(lvl), .irq_lost(lost)
    );

    irq_conditioner #(.N_IRQ(1), .DEBOUNCE_CYCLES(4), .ACTIVE_HIGH(0)) dut_n (
        .clk(clk), .clr(clr), .irq_raw(raw_n), .irq_ack(ack_n),
        .irq_pending(pend_n), .irq_level(lvl_n), .irq_lost(lost_n)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset with random raw inputs, then quiet for 20 cycles
        clr     = 1'b1;
        irq_raw = 3'($urandom_range(7, 0));
        irq_ack = 3'b000;
        raw_n   = 1'b1;
        ack_n   = 1'b0;
        step(2);
        chk("rst_pending", 8'(pend), 8'h00);
        chk("rst_level",   8'(lvl),  8'h00);
        chk("rst_lost",    8'(lost), 8'h00);
        chk("rst_pend_n",  8'(pend_n), 8'h00);
        clr     = 1'b0;
        irq_raw = 3'b000;
        for (int c = 0; c < 20; c++) begin
            step(1);
            chk("idle_all", 8'({pend, lvl, lost}), 8'h00);
        end

        // 2: press ch0, latency of five edges after the first sampling edge
        irq_raw = 3'b001;
        step(5);
        chk("lat_pend_early",  8'(pend), 8'h00);
        chk("lat_level_early", 8'(lvl),  8'h00);
        step(1);
        chk("lat_pend",  8'(pend), 8'h01);
        chk("lat_level", 8'(lvl),  8'h01);
        chk("lat_lost",  8'(lost), 8'h00);

        // 3: ch1 bounces 3 high, 1 low, 3 high -> never accepted
        begin
            logic [12:0] pat;
            pat = 13'b0000001110111;
            for (int c = 0; c < 13; c++) begin
                irq_raw[1] = pat[c];
                step(1);
                chk("bounce_pend",  8'(pend), 8'h01);
                chk("bounce_level", 8'(lvl),  8'h01);
            end
        end

        // 4: ack clears pending; ack with nothing pending is harmless
        irq_ack = 3'b001;
        step(1);
        irq_ack = 3'b000;
        chk("ack_clear", 8'(pend), 8'h00);
        chk("ack_lost",  8'(lost), 8'h00);
        irq_ack = 3'b001;
        step(1);
        irq_ack = 3'b000;
        chk("ack_idle", 8'(pend), 8'h00);
        step(3);
        chk("held_no_rerise", 8'(pend), 8'h00);

        // 5: ch2 press, release, re-press with the rise on the ack edge
        irq_raw[2] = 1'b1;
        step(6);
        chk("ch2_pend", 8'(pend), 8'h04);
        irq_raw[2] = 1'b0;
        step(6);
        chk("ch2_fall_pend",  8'(pend), 8'h04);
        chk("ch2_fall_level", 8'(lvl),  8'h01);
        irq_raw[2] = 1'b1;
        step(5);
        chk("ch2_pre_rise", 8'(lvl), 8'h01);
        irq_ack = 3'b100;
        step(1);
        irq_ack = 3'b000;
        chk("set_wins_pend",  8'(pend), 8'h04);
        chk("set_wins_lost",  8'(lost), 8'h00);
        chk("set_wins_level", 8'(lvl),  8'h05);

        // 6: re-press ch2 while still pending -> lost is sticky
        irq_raw[2] = 1'b0;
        step(6);
        irq_raw[2] = 1'b1;
        step(6);
        chk("overrun_lost", 8'(lost), 8'h04);
        chk("overrun_pend", 8'(pend), 8'h04);
        irq_ack = 3'b100;
        step(1);
        irq_ack = 3'b000;
        step(4);
        chk("sticky_pend", 8'(pend), 8'h00);
        chk("sticky_lost", 8'(lost), 8'h04);

        // 7a: active-low instance idle so far, then press
        chk("actlow_idle", 8'(pend_n), 8'h00);
        raw_n = 1'b0;
        step(5);
        chk("actlow_early", 8'(pend_n), 8'h00);
        step(1);
        chk("actlow_pend",  8'(pend_n), 8'h01);
        chk("actlow_level", 8'(lvl_n),  8'h01);

        // reset overrides everything; ch0 held through reset rises D+2 after
        irq_raw[2] = 1'b0;
        clr        = 1'b1;
        irq_ack    = 3'b111;
        step(1);
        clr     = 1'b0;
        irq_ack = 3'b000;
        chk("clr_lost",    8'(lost),   8'h00);
        chk("clr_pend",    8'(pend),   8'h00);
        chk("clr_pend_n",  8'(pend_n), 8'h00);
        step(5);
        chk("held_rst_early", 8'(pend), 8'h00);
        step(1);
        chk("held_rst_pend", 8'(pend), 8'h01);
        chk("held_rst_lost", 8'(lost), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
